// File: rtl/write_bus_xfer.sv
`default_nettype none
// ============================================================================
// Module      : write_bus_xfer
// Description : Registered write bus with request handshake, per-destination
//               ready wait with timeout, and a sticky error flag.
// Revision    : 1.0
// ============================================================================
module write_bus_xfer #(
    parameter  int BUS_WIDTH = 12,
    parameter  int NUM_SRC   = 16,
    parameter  int NUM_DST   = 16,
    parameter  int TIMEOUT   = 8,
    localparam int SEL_MAX   = (NUM_SRC > NUM_DST) ? NUM_SRC : NUM_DST,
    localparam int SEL_W     = ($clog2(SEL_MAX) < 1) ? 1 : $clog2(SEL_MAX)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC*BUS_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]           src_map,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [SEL_W-1:0]             req_src,
    input  logic [SEL_W-1:0]             req_dst,
    output logic [BUS_WIDTH-1:0]         bus_data,
    output logic [NUM_DST-1:0]           dst_we,
    input  logic [NUM_DST-1:0]           dst_ready,
    output logic                         xfer_done,
    output logic                         bus_err,
    input  logic                         err_clr,
    output logic [7:0]                   xfer_count
);

    localparam int WAIT_W = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]           r_state;
    logic [BUS_WIDTH-1:0] r_bus;
    logic [NUM_DST-1:0]   r_dst_we;
    logic [WAIT_W-1:0]    r_wait;
    logic                 r_done;
    logic                 r_err;
    logic [7:0]           r_count;

    logic [BUS_WIDTH-1:0] w_src_word;
    logic                 w_src_ok;
    logic [NUM_DST-1:0]   w_dst_hot;
    logic                 w_req_ok;
    logic                 w_sel_rdy;
    logic                 w_timeout;
    logic                 w_err_set;

    // Out-of-range selects never match a slot, so they fall out as invalid.
    always_comb begin
        w_src_word = '0;
        w_src_ok   = 1'b0;
        w_dst_hot  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (req_src == SEL_W'(k)) begin
                w_src_word = src_data[k*BUS_WIDTH +: BUS_WIDTH];
                w_src_ok   = src_map[k];
            end
        end
        for (int k = 0; k < NUM_DST; k++) begin
            w_dst_hot[k] = (req_dst == SEL_W'(k));
        end
    end

    assign w_req_ok  = w_src_ok & (|w_dst_hot);
    assign w_sel_rdy = |(dst_ready & r_dst_we);
    assign w_timeout = (r_state == ST_DRIVE) & ~w_sel_rdy & (r_wait == c_WAIT_LAST);
    assign w_err_set = ((r_state == ST_IDLE) & req_valid & ~w_req_ok) | w_timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_bus    <= '0;
            r_dst_we <= '0;
            r_wait   <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= 8'd0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (req_valid && w_req_ok) begin
                    r_bus    <= w_src_word;
                    r_dst_we <= w_dst_hot;
                    r_wait   <= '0;
                    r_state  <= ST_DRIVE;
                end
            end else begin
                if (w_sel_rdy) begin
                    r_state  <= ST_IDLE;
                    r_dst_we <= '0;
                    r_done   <= 1'b1;
                    r_count  <= r_count + 8'd1;
                end else if (w_timeout) begin
                    r_state  <= ST_IDLE;
                    r_dst_we <= '0;
                end else begin
                    r_wait <= r_wait + WAIT_W'(1);
                end
            end

            // A new error in the same cycle as a clear keeps the flag set.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE) & rst_n;
    assign bus_data   = r_bus;
    assign dst_we     = r_dst_we;
    assign xfer_done  = r_done;
    assign bus_err    = r_err;
    assign xfer_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_write_bus_xfer.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_bus_xfer
// Description : Scoreboard-based self-checking bench for write_bus_xfer.
// Revision    : 1.0
// ============================================================================
module tb_write_bus_xfer;

    localparam int BW = 12;
    localparam int NS = 16;
    localparam int ND = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS*BW-1:0]  src_data;
    logic [NS-1:0]     src_map;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_src;
    logic [3:0]        req_dst;
    logic [BW-1:0]     bus_data;
    logic [ND-1:0]     dst_we;
    logic [ND-1:0]     dst_ready;
    logic              xfer_done;
    logic              bus_err;
    logic              err_clr;
    logic [7:0]        xfer_count;

    int checks   = 0;
    int failures = 0;

    // Expected {dst_we, bus_data} per accepted transfer.
    logic [ND+BW-1:0] sb[$];

    always #5 clk = ~clk;

    write_bus_xfer #(
        .BUS_WIDTH (BW),
        .NUM_SRC   (NS),
        .NUM_DST   (ND),
        .TIMEOUT   (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_data   (src_data),
        .src_map    (src_map),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .bus_data   (bus_data),
        .dst_we     (dst_we),
        .dst_ready  (dst_ready),
        .xfer_done  (xfer_done),
        .bus_err    (bus_err),
        .err_clr    (err_clr),
        .xfer_count (xfer_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input logic [BW-1:0] v);
        src_data[k*BW +: BW] = v;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        err_clr   = 1'b0;
        dst_ready = '0;
        src_map   = '1;
        src_data  = '0;
        req_src   = '0;
        req_dst   = '0;
        tick();
        tick();
        checks++; if (bus_data !== 12'h000) begin failures++; $display("FAIL reset_bus_data got=%h exp=000", bus_data); end
        checks++; if (dst_we !== 16'h0000) begin failures++; $display("FAIL reset_dst_we got=%h exp=0000", dst_we); end
        checks++; if (xfer_done !== 1'b0) begin failures++; $display("FAIL reset_xfer_done got=%b exp=0", xfer_done); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
        checks++; if (xfer_count !== 8'd0) begin failures++; $display("FAIL reset_xfer_count got=%0d exp=0", xfer_count); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready_low got=%b exp=0", req_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready_high got=%b exp=1", req_ready); end
        sb.delete();
    endtask

    task automatic test_basic();
        logic [ND+BW-1:0] e;
        set_slot(2, 12'h0A5);
        dst_ready = 16'h0040;
        req_src   = 4'd2;
        req_dst   = 4'd6;
        req_valid = 1'b1;
        sb.push_back({16'h0040, 12'h0A5});
        tick();
        req_valid = 1'b0;
        set_slot(2, 12'hFFF);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++; $display("FAIL basic_scoreboard_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            if ({dst_we, bus_data} !== e) begin
                failures++; $display("FAIL basic_write got=%h/%h exp=%h/%h", dst_we, bus_data, e[ND+BW-1:BW], e[BW-1:0]);
            end
        end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL basic_req_ready_drive got=%b exp=0", req_ready); end
        checks++; if (xfer_done !== 1'b0) begin failures++; $display("FAIL basic_done_early got=%b exp=0", xfer_done); end
        tick();
        checks++; if (dst_we !== 16'h0000) begin failures++; $display("FAIL basic_we_clear got=%h exp=0000", dst_we); end
        checks++; if (xfer_done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", xfer_done); end
        checks++; if (xfer_count !== 8'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", xfer_count); end
        checks++; if (bus_data !== 12'h0A5) begin failures++; $display("FAIL basic_src_sampled_once got=%h exp=0a5", bus_data); end
        tick();
        checks++; if (xfer_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", xfer_done); end
    endtask

    task automatic test_timeout();
        logic [ND+BW-1:0] e;
        int  hi;
        bit  popped;
        bit  done_seen;
        set_slot(3, 12'h123);
        dst_ready = '0;
        req_src   = 4'd3;
        req_dst   = 4'd5;
        req_valid = 1'b1;
        sb.push_back({16'h0020, 12'h123});
        tick();
        req_valid = 1'b0;
        hi        = 0;
        popped    = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 20 && dst_we != '0; c++) begin
            hi++;
            if (xfer_done) done_seen = 1'b1;
            if (!popped) begin
                popped = 1'b1;
                e = sb.pop_front();
                checks++;
                if ({dst_we, bus_data} !== e) begin
                    failures++; $display("FAIL timeout_write got=%h/%h exp=%h/%h", dst_we, bus_data, e[ND+BW-1:BW], e[BW-1:0]);
                end
            end
            tick();
        end
        checks++; if (hi !== 8) begin failures++; $display("FAIL timeout_we_cycles got=%0d exp=8", hi); end
        checks++; if (done_seen || xfer_done !== 1'b0) begin failures++; $display("FAIL timeout_no_done got=%b exp=0", done_seen | xfer_done); end
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", bus_err); end
        checks++; if (xfer_count !== 8'd1) begin failures++; $display("FAIL timeout_count got=%0d exp=1", xfer_count); end
        checks++; if (bus_data !== 12'h123) begin failures++; $display("FAIL timeout_bus_hold got=%h exp=123", bus_data); end
        tick();
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL timeout_err_sticky got=%b exp=1", bus_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL timeout_err_clr got=%b exp=0", bus_err); end
    endtask

    task automatic test_unmapped();
        bit any_we;
        src_map   = 16'hFDFF;
        set_slot(9, 12'h777);
        dst_ready = '1;
        req_src   = 4'd9;
        req_dst   = 4'd1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL unmapped_err got=%b exp=1", bus_err); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL unmapped_ready got=%b exp=1", req_ready); end
        checks++; if (bus_data !== 12'h123) begin failures++; $display("FAIL unmapped_bus_hold got=%h exp=123", bus_data); end
        any_we = (dst_we != '0);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (dst_we != '0 || xfer_done) any_we = 1'b1;
        end
        checks++; if (any_we !== 1'b0) begin failures++; $display("FAIL unmapped_no_write got=%b exp=0", any_we); end
        checks++; if (xfer_count !== 8'd1) begin failures++; $display("FAIL unmapped_count got=%0d exp=1", xfer_count); end
        err_clr = 1'b1;
        tick();
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL unmapped_clr got=%b exp=0", bus_err); end
        // Set and clear in the same cycle: set must win.
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        err_clr   = 1'b0;
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL err_set_wins got=%b exp=1", bus_err); end
        src_map = '1;
    endtask

    task automatic test_other_ready_ignored();
        logic [ND+BW-1:0] e;
        bit bad;
        set_slot(7, 12'h3C3);
        dst_ready = ~16'h0010;
        req_src   = 4'd7;
        req_dst   = 4'd4;
        req_valid = 1'b1;
        sb.push_back({16'h0010, 12'h3C3});
        tick();
        req_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({dst_we, bus_data} !== e) begin
            failures++; $display("FAIL ignore_write got=%h/%h exp=%h/%h", dst_we, bus_data, e[ND+BW-1:BW], e[BW-1:0]);
        end
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (dst_we !== 16'h0010 || xfer_done !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL ignore_other_ready got=%h exp=0010", dst_we); end
        dst_ready = 16'h0010;
        tick();
        checks++; if (xfer_done !== 1'b1) begin failures++; $display("FAIL ignore_done got=%b exp=1", xfer_done); end
        checks++; if (xfer_count !== 8'd2) begin failures++; $display("FAIL ignore_count got=%0d exp=2", xfer_count); end
    endtask

    task automatic test_reset_mid_drive();
        set_slot(1, 12'h5A5);
        dst_ready = '0;
        req_src   = 4'd1;
        req_dst   = 4'd0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (dst_we !== 16'h0001) begin failures++; $display("FAIL rstdrv_we got=%h exp=0001", dst_we); end
        rst_n = 1'b0;
        tick();
        checks++; if (dst_we !== 16'h0000) begin failures++; $display("FAIL rstdrv_we_clear got=%h exp=0000", dst_we); end
        checks++; if (bus_data !== 12'h000) begin failures++; $display("FAIL rstdrv_bus got=%h exp=000", bus_data); end
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL rstdrv_err got=%b exp=0", bus_err); end
        checks++; if (xfer_count !== 8'd0) begin failures++; $display("FAIL rstdrv_count got=%0d exp=0", xfer_count); end
        rst_n = 1'b1;
        tick();
        checks++; if (xfer_done !== 1'b0 || dst_we !== 16'h0000) begin failures++; $display("FAIL rstdrv_silent got=%b/%h exp=0/0000", xfer_done, dst_we); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rstdrv_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_back_to_back();
        logic [ND+BW-1:0] e;
        logic [BW-1:0]    v;
        logic [ND-1:0]    oh;
        int               s;
        int               d;
        dst_ready = '1;
        req_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            s  = int'($urandom_range(0, NS - 1));
            d  = int'($urandom_range(0, ND - 1));
            v  = BW'($urandom);
            oh = ND'(1) << d;
            set_slot(s, v);
            req_src = 4'(s);
            req_dst = 4'(d);
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, req_ready); end
            sb.push_back({oh, v});
            tick();
            checks++;
            if (sb.size() == 0) begin
                failures++; $display("FAIL b2b_scoreboard_empty i=%0d got=0 exp=1", i);
            end else begin
                e = sb.pop_front();
                if ({dst_we, bus_data} !== e) begin
                    failures++; $display("FAIL b2b_write i=%0d got=%h/%h exp=%h/%h", i, dst_we, bus_data, e[ND+BW-1:BW], e[BW-1:0]);
                end
            end
            tick();
            checks++; if (xfer_done !== 1'b1) begin failures++; $display("FAIL b2b_done i=%0d got=%b exp=1", i, xfer_done); end
            if (i == 254) begin
                checks++; if (xfer_count !== 8'd255) begin failures++; $display("FAIL b2b_count_255 got=%0d exp=255", xfer_count); end
            end
        end
        req_valid = 1'b0;
        checks++; if (xfer_count !== 8'd0) begin failures++; $display("FAIL b2b_count_wrap got=%0d exp=0", xfer_count); end
        tick();
        checks++; if (xfer_done !== 1'b0) begin failures++; $display("FAIL b2b_idle_done got=%b exp=0", xfer_done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_unmapped();
        test_other_ready_ignored();
        test_reset_mid_drive();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
